// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory request bus between the fetch sequencer (master) and imem (slave).
interface pc_fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;

  modport master (output imem_req, output imem_addr, input imem_ready);
  modport slave  (input imem_req, input imem_addr, output imem_ready);
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Fetch PC owner: sequences imem requests, applies execute-stage redirects, squashes wrong-path fetches.
// Optional misaligned-target trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        stall,
  input  logic                        ex_valid,
  input  logic                        jump_flag,
  input  logic [31:0]                 jump_target,
  pc_fetch_sequencer_if.master        imem,
  output logic                        if_valid,
  output logic [31:0]                 if_pc,
  output logic                        flush,
  output logic [31:0]                 pc_q,
  output logic                        misalign_exc
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_d;
  logic [31:0] redir_q, redir_d;
  logic        req_q, req_d;
  logic        taken, mis;
  logic [31:0] tgt;
  logic        rdy;

  assign taken = ex_valid & jump_flag;
  assign rdy   = imem.imem_ready;

`ifdef PC_MISALIGN_TRAP_EN
  assign mis = taken & (jump_target[1:0] != 2'b00);
  assign tgt = (jump_target[1:0] != 2'b00) ? TRAP_VECTOR : jump_target;
`else
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^{jump_target[1:0], TRAP_VECTOR};
  assign mis = 1'b0;
  assign tgt = {jump_target[31:2], 2'b00};
`endif

  assign flush          = taken;
  assign misalign_exc   = mis;
  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign if_pc          = pc_q;
  assign if_valid       = (state_q == S_REQ) & rdy & ~taken;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    redir_d = redir_q;
    case (state_q)
      S_IDLE: begin
        if (taken) pc_d = tgt;
        state_d = stall ? S_IDLE : S_REQ;
      end
      S_REQ: begin
        if (rdy) begin
          pc_d    = taken ? tgt : pc_q + 32'd4;
          state_d = stall ? S_IDLE : S_REQ;
        end else if (taken) begin
          // request must stay stable on the bus; park the redirect until accepted
          redir_d = tgt;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (taken) redir_d = tgt;
        if (rdy) begin
          pc_d    = taken ? tgt : redir_q;
          state_d = stall ? S_IDLE : S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      redir_q <= 32'h0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
      req_q   <= req_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Vector table, hand sequences, then randomized run against a request/squash reference model.
module tb_pc_fetch_sequencer;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR = 32'h0000_0100;
`ifdef PC_MISALIGN_TRAP_EN
  localparam logic        MIS_ON  = 1'b1;
  localparam logic [31:0] MIS_TGT = TRAP_VECTOR;
`else
  localparam logic        MIS_ON  = 1'b0;
  localparam logic [31:0] MIS_TGT = 32'h0000_0200;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, ex_valid, jump_flag;
  logic [31:0] jump_target;
  logic        if_valid, flush, misalign_exc;
  logic [31:0] if_pc, pc_q;

  pc_fetch_sequencer_if bus ();

  pc_fetch_sequencer #(.RESET_PC(RESET_PC), .TRAP_VECTOR(TRAP_VECTOR)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .ex_valid(ex_valid),
    .jump_flag(jump_flag), .jump_target(jump_target), .imem(bus.master),
    .if_valid(if_valid), .if_pc(if_pc), .flush(flush), .pc_q(pc_q),
    .misalign_exc(misalign_exc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        s, ev, jf;
    logic [31:0] jt;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        ifv, fl, mis;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic ev, input logic jf,
                       input logic [31:0] jt, input logic rdy);
    stall = s; ex_valid = ev; jump_flag = jf; jump_target = jt; bus.imem_ready = rdy;
  endtask

  task automatic step(input string nm, input logic s, input logic ev, input logic jf,
                      input logic [31:0] jt, input logic rdy,
                      input logic ereq, input logic [31:0] eaddr,
                      input logic eifv, input logic efl, input logic emis);
    drive(s, ev, jf, jt, rdy);
    @(negedge clk);
    chk({nm, ".req"},   {31'b0, bus.imem_req}, {31'b0, ereq});
    chk({nm, ".addr"},  bus.imem_addr, eaddr);
    chk({nm, ".if_pc"}, if_pc, eaddr);
    chk({nm, ".pc_q"},  pc_q, eaddr);
    chk({nm, ".ifv"},   {31'b0, if_valid}, {31'b0, eifv});
    chk({nm, ".flush"}, {31'b0, flush}, {31'b0, efl});
    chk({nm, ".mis"},   {31'b0, misalign_exc}, {31'b0, emis});
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input string nm);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk({nm, ".req"},  {31'b0, bus.imem_req}, 32'h0);
    chk({nm, ".addr"}, bus.imem_addr, RESET_PC);
    chk({nm, ".ifv"},  {31'b0, if_valid}, 32'h0);
    chk({nm, ".flush"}, {31'b0, flush}, 32'h0);
    chk({nm, ".mis"},  {31'b0, misalign_exc}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // reference model: an outstanding request, whether it has been squashed, and the redirect to take
  logic        m_active, m_sq;
  logic [31:0] m_pc, m_pend;

  function automatic logic [31:0] redirect_of(input logic [31:0] jt);
`ifdef PC_MISALIGN_TRAP_EN
    return (jt % 4 != 0) ? TRAP_VECTOR : jt;
`else
    return jt - (jt % 4);
`endif
  endfunction

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    //          s  ev jf  jt           rdy  req addr          ifv fl mis
    tbl[0]  = '{0, 0, 0, 32'h0,       1,   0, 32'h0,        0,  0, 0};
    tbl[1]  = '{0, 0, 0, 32'h0,       1,   1, 32'h0,        1,  0, 0};
    tbl[2]  = '{0, 0, 0, 32'h0,       1,   1, 32'h4,        1,  0, 0};
    tbl[3]  = '{0, 0, 0, 32'h0,       1,   1, 32'h8,        1,  0, 0};
    tbl[4]  = '{0, 0, 0, 32'h0,       1,   1, 32'hC,        1,  0, 0};
    tbl[5]  = '{0, 1, 1, 32'h200,     1,   1, 32'h10,       0,  1, 0};
    tbl[6]  = '{0, 1, 1, 32'h300,     0,   1, 32'h200,      0,  1, 0};
    tbl[7]  = '{0, 0, 1, 32'h0,       0,   1, 32'h200,      0,  0, 0};
    tbl[8]  = '{0, 0, 0, 32'h0,       1,   1, 32'h200,      0,  0, 0};
    tbl[9]  = '{0, 0, 0, 32'h0,       1,   1, 32'h300,      1,  0, 0};
    tbl[10] = '{1, 0, 0, 32'h0,       1,   1, 32'h304,      1,  0, 0};
    tbl[11] = '{1, 0, 0, 32'h0,       1,   0, 32'h308,      0,  0, 0};
    tbl[12] = '{0, 0, 0, 32'h0,       0,   0, 32'h308,      0,  0, 0};
    tbl[13] = '{0, 0, 0, 32'h0,       1,   1, 32'h308,      1,  0, 0};
    tbl[14] = '{0, 1, 1, 32'h202,     1,   1, 32'h30C,      0,  1, MIS_ON};
    tbl[15] = '{0, 0, 0, 32'h0,       0,   1, MIS_TGT,      0,  0, 0};

    do_reset("reset");
    foreach (tbl[i])
      step($sformatf("tbl%0d", i), tbl[i].s, tbl[i].ev, tbl[i].jf, tbl[i].jt, tbl[i].rdy,
           tbl[i].req, tbl[i].addr, tbl[i].ifv, tbl[i].fl, tbl[i].mis);

    // stall while a request is pending must not drop it
    step("st0", 0, 1, 1, 32'h40, 1, 1, MIS_TGT, 0, 1, 0);
    step("st1", 1, 0, 0, 32'h0, 0, 1, 32'h40, 0, 0, 0);
    step("st2", 1, 0, 0, 32'h0, 0, 1, 32'h40, 0, 0, 0);
    step("st3", 1, 0, 0, 32'h0, 1, 1, 32'h40, 1, 0, 0);
    step("st4", 1, 0, 0, 32'h0, 1, 0, 32'h44, 0, 0, 0);
    step("st5", 0, 0, 0, 32'h0, 0, 0, 32'h44, 0, 0, 0);
    step("st6", 0, 0, 0, 32'h0, 1, 1, 32'h44, 1, 0, 0);
    // wrap past the top of the address space
    step("wr0", 0, 1, 1, 32'hFFFF_FFFC, 1, 1, 32'h48, 0, 1, 0);
    step("wr1", 0, 0, 0, 32'h0, 1, 1, 32'hFFFF_FFFC, 1, 0, 0);
    step("wr2", 0, 0, 0, 32'h0, 0, 1, 32'h0, 0, 0, 0);
    do_reset("midreset");
    // two redirects while draining: latest wins
    step("dr0", 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
    step("dr1", 0, 1, 1, 32'h500, 0, 1, 32'h0, 0, 1, 0);
    step("dr2", 0, 1, 1, 32'h600, 0, 1, 32'h0, 0, 1, 0);
    step("dr3", 0, 0, 0, 32'h0, 1, 1, 32'h0, 0, 0, 0);
    step("dr4", 0, 0, 0, 32'h0, 1, 1, 32'h600, 1, 0, 0);

    // randomized run against the reference model
    do_reset("rreset");
    m_active = 1'b0; m_sq = 1'b0; m_pc = RESET_PC; m_pend = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      logic        s, ev, jf, rdy, tk, eifv;
      logic [31:0] jt;
      s   = ($urandom_range(0, 3) == 0);
      ev  = ($urandom_range(0, 1) == 0);
      jf  = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 4) < 3);
      jt  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      drive(s, ev, jf, jt, rdy);
      tk   = ev & jf;
      eifv = m_active & ~m_sq & rdy & ~tk;
      @(negedge clk);
      chk("rnd.req",   {31'b0, bus.imem_req}, {31'b0, m_active});
      chk("rnd.addr",  bus.imem_addr, m_pc);
      chk("rnd.if_pc", if_pc, m_pc);
      chk("rnd.ifv",   {31'b0, if_valid}, {31'b0, eifv});
      chk("rnd.flush", {31'b0, flush}, {31'b0, tk});
      chk("rnd.mis",   {31'b0, misalign_exc}, {31'b0, MIS_ON & tk & (jt % 4 != 0)});
      if (!m_active) begin
        if (tk) m_pc = redirect_of(jt);
        m_active = ~s;
      end else begin
        if (tk) begin
          m_sq   = 1'b1;
          m_pend = redirect_of(jt);
        end
        if (rdy) begin
          m_pc     = m_sq ? m_pend : m_pc + 32'd4;
          m_sq     = 1'b0;
          m_active = ~s;
        end
      end
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Owns the architectural fetch PC and sequences instruction-memory requests for the fetch stage.
- Applies taken-branch/jump redirects from the execute-stage jump unit (jump_flag/jump_target) and squashes wrong-path fetches.
- Issues the pipeline flush pulse.
- Sits between the execute-stage jump unit, the hazard/stall logic and the instruction-memory port.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, redirect address for a misaligned target (used only with the optional feature).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hazard unit: do not start a new fetch
- ex_valid  in  1  execute-stage instruction valid
- jump_flag  in  1  execute-stage branch/jump taken
- jump_target  in  32  execute-stage redirect address
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address
- imem_ready  in  1  memory accepts request; instruction returned same cycle
- if_valid  out  1  fetched instruction this cycle is valid (not squashed)
- if_pc  out  32  PC of the instruction returned this cycle
- flush  out  1  kill IF/ID and ID/EX pipeline registers
- pc_q  out  32  current fetch PC register
- misalign_exc  out  1  misaligned-target pulse (optional feature only; tied 0 otherwise)

Behaviour:
- Reset: asynchronous on rst_n low. State=S_IDLE, pc=RESET_PC, redirect_pc=0. imem_req=0, if_valid=0, flush=0, misalign_exc=0, imem_addr=if_pc=pc_q=RESET_PC. Reset asserted mid-request abandons the request; no completion is signalled.
- taken = ex_valid & jump_flag. flush = taken, combinational, zero latency.
- tgt = jump_target with bits[1:0] forced to 0 (see optional feature).
- imem_addr = pc_q and if_pc = pc_q always. pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Handshake: once imem_req=1, imem_req and imem_addr stay stable until the cycle imem_ready=1. stall never drops an asserted request.
- S_IDLE (imem_req=0):
  - taken -> pc<=tgt.
  - next = S_REQ if !stall, else S_IDLE.
- S_REQ (imem_req=1):
  - ready & !taken -> if_valid=1; pc<=pc+4; next = stall ? S_IDLE : S_REQ.
  - ready & taken -> if_valid=0 (wrong path); pc<=tgt; next = stall ? S_IDLE : S_REQ.
  - !ready & taken -> redirect_pc<=tgt; next S_DRAIN.
  - !ready & !taken -> hold.
- S_DRAIN (imem_req=1, old address held):
  - if_valid=0 always.
  - taken again -> redirect_pc<=tgt (latest wins).
  - ready -> pc<=(taken ? tgt : redirect_pc); next = stall ? S_IDLE : S_REQ.
- if_valid = (state==S_REQ) & imem_ready & !taken. Combinational; 0 in S_IDLE and S_DRAIN.
- Fetch throughput: one instruction per cycle when imem_ready=1 and stall=0.
- Redirect latency: target is on imem_addr in the cycle after the redirect is applied.
- Unused state encoding -> S_IDLE.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined: a taken redirect whose jump_target[1:0]!=0 pulses misalign_exc for one cycle, with the same timing as flush. tgt becomes TRAP_VECTOR instead of the masked target.
- Undefined: misalign_exc tied 0; jump_target[1:0] silently cleared.

Test Plan:
- Reset release, stall=0, imem_ready=1 constantly -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles; if_valid=1 each cycle.
- In S_REQ at pc=0x10, imem_ready=1, taken with jump_target=0x200 -> flush=1, if_valid=0 that cycle; next cycle imem_addr=0x200.
- imem_ready=0 at pc=0x20, taken with target 0x300, then ready=1 two cycles later:
  - imem_addr stays 0x20 throughout the wait.
  - if_valid=0 on the accept cycle.
  - Next cycle imem_addr=0x300.
- stall=1 while request pending at 0x40 with ready=0 for 2 cycles -> imem_req stays 1 until ready. Then imem_req=0 while stall held; on stall release, fetch resumes at 0x44.
- pc=0xFFFF_FFFC accepted -> next imem_addr=0x0000_0000.
- Target 0x202:
  - Without PC_MISALIGN_TRAP_EN -> redirect to 0x200.
  - With PC_MISALIGN_TRAP_EN -> misalign_exc one-cycle pulse and redirect to TRAP_VECTOR (0x100).
